axi_bram_hs_writer: RTL and testbench
=====================================

# axi_bram_hs_writer

AXI4-Lite slave that writes into one BRAM port with fully decoupled write-address and write-data channels, registered BRAM outputs, and a correctly back-pressured write-response channel. Each of the AW and W channels has its own single-entry holding register. A BRAM write is committed only when both entries are held and the B channel can take a response. The block sits between the PS/interconnect AXI4-Lite master and a true-dual-port BRAM whose other port belongs to PL logic. It also exports a running count of committed writes for status registers.

## Interface
- AXI_DATA_WIDTH, 32: AXI data width. Equals BRAM_DATA_WIDTH; legal values 32 or 64.
- AXI_ADDR_WIDTH, 32: AXI byte-address width.
- BRAM_DATA_WIDTH, 32: BRAM word width.
- BRAM_ADDR_WIDTH, 10: BRAM word-address width.
- BRAM_DEPTH, 1024: number of implemented words, ≤ 2^BRAM_ADDR_WIDTH.
- CNT_WIDTH, 32: width of the committed-write counter.
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1 each  AW handshake.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1 each  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1 each  B handshake.
- bram_porta_clk  out  1  driven by aclk.
- bram_porta_rst  out  1  equals ~aresetn.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  registered word address.
- bram_porta_wrdata  out  BRAM_DATA_WIDTH  registered write data.
- bram_porta_we  out  BRAM_DATA_WIDTH/8  registered byte enables.
- sts_wr_count  out  CNT_WIDTH  number of committed writes, wrapping.

## Operation
- ADDR_LSB = log2(AXI_DATA_WIDTH/8). Word index = awaddr[ADDR_LSB+BRAM_ADDR_WIDTH-1:ADDR_LSB]. Upper address bits are ignored.
- AW holding register:
  - State: aw_full flag plus stored word index.
  - s_axi_awready = ~aw_full.
  - AW handshake (awvalid & awready): capture the index and set aw_full.
- W holding register:
  - State: w_full flag plus stored data and strobe.
  - s_axi_wready = ~w_full.
  - W handshake: capture data and strobe, set w_full.
- Channel order: AW and W may arrive in either order or in the same cycle, with any gap between them.
- Commit condition: aw_full & w_full & (~bvalid_reg | s_axi_bready).
- On a commit edge:
  - bram_porta_addr, bram_porta_wrdata and bram_porta_we load the held values.
  - aw_full and w_full clear.
  - bvalid_reg sets and bresp is loaded.
  - sts_wr_count increments, but only when the write was actually issued.
- On any non-commit edge, bram_porta_we loads zero, so we is asserted for exactly one cycle per write.
- A commit and a B handshake in the same cycle leave bvalid high with the new bresp.
- A B handshake without a commit clears bvalid.
- bresp is 2'b00 (OKAY) except as stated under Configuration.
- Strobe 0 is a legal write: the handshakes complete, we stays 0, and the counter still increments.

## Timing
- Reset values (asynchronous, while aresetn low):
  - awready = 0, wready = 0.
  - bvalid = 0, bresp = 0.
  - bram_porta_we = 0, bram_porta_addr = 0, bram_porta_wrdata = 0.
  - sts_wr_count = 0; aw_full = 0, w_full = 0.
- awready and wready go to 1 on the first aclk edge after aresetn deasserts.
- Latency: AW and W accepted at edge N → bram_porta_we asserted in cycle N+1 (visible after edge N+1) → bvalid high after edge N+1.
- Throughput: one write per 2 cycles sustained, because ready is deasserted while the entry is held.
- B backpressure: while bvalid = 1 and bready = 0, a fully held AW+W pair waits. awready and wready stay 0, and no BRAM write occurs.
- Reset asserted mid-transaction drops held entries and any pending response. No BRAM write is issued after reset asserts.
- sts_wr_count wraps from 2^CNT_WIDTH−1 to 0.

## Configuration
- AXI_BRAM_HS_WRITER_RANGE_CHECK_EN defined:
  - A committed write whose word index ≥ BRAM_DEPTH returns bresp = 2'b10 (SLVERR).
  - bram_porta_we stays 0 for that write.
  - sts_wr_count does not increment.
- Not defined: no range comparison; every write returns OKAY and is issued. Only the low BRAM_ADDR_WIDTH index bits are used, so out-of-range indices alias within the BRAM.

## Test plan
- Simultaneous handshake: AW 0x0000_0010, W 0xDEADBEEF, strb 0xF in the same cycle, bready = 1 → one cycle later addr = 4, wrdata = 0xDEADBEEF, we = 0xF for exactly one cycle; bvalid = 1 with bresp = 0; count = 1.
- W leads AW by 5 cycles: wready drops after the W handshake and no write occurs until AW 0x0000_0008 arrives → then addr = 2, single we pulse.
- B backpressure: bready = 0 for 10 cycles while two writes are offered → first write issued; the second pair is held with awready = wready = 0 and we = 0; it commits in the cycle bready rises; count = 2.
- Byte strobes: strb 0x5, data 0x11223344 → we = 0x5. Strb 0x0 → we stays 0, bresp = OKAY, count increments.
- With the macro defined, BRAM_DEPTH = 1000, write to word 1000 (byte address 0x0FA0) → bresp = SLVERR, we = 0, count unchanged. Without the macro, the same write gives OKAY and a we pulse at addr = 1000.
- Reset with aw_full = 1 and w_full = 0, then release and send W only → no write occurs, bvalid stays 0, count = 0.

Source files
------------

// File: rtl/axi_bram_hs_writer.sv
// axi_bram_hs_writer
//
// AXI4-Lite write-only slave that drives one port of a true-dual-port BRAM.
// The AW and W channels each have a single-entry holding register, so the
// master can present them in any order or in the same cycle, with any gap
// between them. A BRAM write is committed only when both entries are held
// and the B channel can accept a response. The address, data and byte
// enables driven to the BRAM are registered, and bram_porta_we is high for
// exactly one cycle per issued write.
//
// Optional feature (compile-time macro AXI_BRAM_HS_WRITER_RANGE_CHECK_EN):
//   a write whose word index is >= BRAM_DEPTH is answered with SLVERR, is
//   not issued to the BRAM and is not counted. Without the macro, every
//   write is issued and answered OKAY, and out-of-range indices alias
//   within the BRAM.
//
// Ports:
//   aclk, aresetn          single clock, asynchronous active-low reset
//   s_axi_aw*              write-address channel (awready = entry empty)
//   s_axi_w*               write-data channel (wready = entry empty)
//   s_axi_b*               write-response channel
//   bram_porta_*           BRAM port A: clock, reset, registered addr/data/we
//   sts_wr_count           running count of issued writes, wraps at 2^CNT_WIDTH

module axi_bram_hs_writer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DEPTH      = 1024,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic                         bram_porta_clk,
    output logic                         bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
    output logic [CNT_WIDTH-1:0]         sts_wr_count
);

    localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    // One extra bit so BRAM_DEPTH == 2^BRAM_ADDR_WIDTH is representable.
    localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_L = (BRAM_ADDR_WIDTH + 1)'(BRAM_DEPTH);
`ifdef AXI_BRAM_HS_WRITER_RANGE_CHECK_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

    // Holds readies low until the first clock edge after reset release.
    logic                         rdy_q, rdy_d;

    logic                         aw_full_q, aw_full_d;
    logic [BRAM_ADDR_WIDTH-1:0]   aw_idx_q, aw_idx_d;

    logic                         w_full_q, w_full_d;
    logic [BRAM_DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [BRAM_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;

    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;

    logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BRAM_DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [BRAM_DATA_WIDTH/8-1:0] we_q, we_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

    logic                         aw_hs, w_hs, commit, issue;
    logic [1:0]                   resp;

    // Upper address bits and byte-offset bits are intentionally ignored.
    logic                         unused_ok;
    assign unused_ok = ^{s_axi_awaddr, DEPTH_L};

    assign s_axi_awready     = rdy_q & ~aw_full_q;
    assign s_axi_wready      = rdy_q & ~w_full_q;
    assign s_axi_bvalid      = bvalid_q;
    assign s_axi_bresp       = bresp_q;
    assign bram_porta_clk    = aclk;
    assign bram_porta_rst    = ~aresetn;
    assign bram_porta_addr   = addr_q;
    assign bram_porta_wrdata = wrdata_q;
    assign bram_porta_we     = we_q;
    assign sts_wr_count      = cnt_q;

    always_comb begin
        aw_hs  = s_axi_awvalid & s_axi_awready;
        w_hs   = s_axi_wvalid & s_axi_wready;
        // A response slot is free if none is pending or the pending one is
        // being accepted this cycle.
        commit = aw_full_q & w_full_q & (~bvalid_q | s_axi_bready);
`ifdef AXI_BRAM_HS_WRITER_RANGE_CHECK_EN
        if ({1'b0, aw_idx_q} < DEPTH_L) begin
            issue = commit;
            resp  = RESP_OKAY;
        end else begin
            issue = 1'b0;
            resp  = RESP_SLVERR;
        end
`else
        issue = commit;
        resp  = RESP_OKAY;
`endif
    end

    always_comb begin
        rdy_d     = 1'b1;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;
        we_d      = '0;
        cnt_d     = cnt_q;

        // A handshake can only happen on an empty entry and a commit only
        // on a full one, so these never collide within one channel.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            addr_d    = aw_idx_q;
            wrdata_d  = w_data_q;
            bvalid_d  = 1'b1;
            bresp_d   = resp;
        end else if (s_axi_bready) begin
            bvalid_d  = 1'b0;
        end

        if (issue) begin
            we_d  = w_strb_q;
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
        end

        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q     <= 1'b0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            wrdata_q  <= '0;
            we_q      <= '0;
            cnt_q     <= '0;
        end else begin
            rdy_q     <= rdy_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_bram_hs_writer.sv
`timescale 1ns/1ps
module tb_axi_bram_hs_writer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int BAW   = 10;
    localparam int DEPTH = 1000;
    localparam int CW    = 4;
    localparam int SW    = DW / 8;
`ifdef AXI_BRAM_HS_WRITER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] awaddr  = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata   = '0;
    logic [SW-1:0] wstrb   = '0;
    logic          wvalid  = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready  = 1'b0;
    logic          bclk, brst;
    logic [BAW-1:0] baddr;
    logic [DW-1:0] bwrdata;
    logic [SW-1:0] bwe;
    logic [CW-1:0] cnt;

    int errors = 0;
    int checks = 0;

    axi_bram_hs_writer #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(BAW),
        .BRAM_DEPTH     (DEPTH),
        .CNT_WIDTH      (CW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axi_awaddr     (awaddr),
        .s_axi_awvalid    (awvalid),
        .s_axi_awready    (awready),
        .s_axi_wdata      (wdata),
        .s_axi_wstrb      (wstrb),
        .s_axi_wvalid     (wvalid),
        .s_axi_wready     (wready),
        .s_axi_bresp      (bresp),
        .s_axi_bvalid     (bvalid),
        .s_axi_bready     (bready),
        .bram_porta_clk   (bclk),
        .bram_porta_rst   (brst),
        .bram_porta_addr  (baddr),
        .bram_porta_wrdata(bwrdata),
        .bram_porta_we    (bwe),
        .sts_wr_count     (cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit in_rng(input int unsigned idx);
        return !RC || (idx < DEPTH);
    endfunction

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic [9:0]   exp_addr;
        logic [3:0]   exp_we;
        logic [1:0]   exp_resp;
        bit           exp_inc;
    } vec_t;

    // Transaction-level reference model for the random phase.
    int unsigned    m_aw[$];
    logic [DW-1:0]  m_wd[$];
    logic [SW-1:0]  m_ws[$];
    bit             m_bv;
    logic [1:0]     m_resp;
    logic [BAW-1:0] m_addr;
    logic [DW-1:0]  m_data;
    logic [SW-1:0]  m_we;
    logic [CW-1:0]  m_cnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [CW-1:0] exp_cnt;
        bit aw_hs, w_hs, commit, ok;
        int unsigned idx;
        logic [DW-1:0] d;
        logic [SW-1:0] s;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 10'd4,    4'hF, 2'b00, 1'b1};
        vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'h5, 10'd8,    4'h5, 2'b00, 1'b1};
        vecs[2] = '{32'h0000_0030, 32'hAABB_CCDD, 4'h0, 10'd12,   4'h0, 2'b00, 1'b1};
        vecs[3] = '{32'h0000_0FA0, 32'h1234_5678, 4'hF, 10'd1000,
                    RC ? 4'h0 : 4'hF, RC ? 2'b10 : 2'b00, !RC};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0102_0304, 4'h3, 10'd1023,
                    RC ? 4'h0 : 4'h3, RC ? 2'b10 : 2'b00, !RC};
        vecs[5] = '{32'h1234_0004, 32'h5566_7788, 4'hA, 10'd1,    4'hA, 2'b00, 1'b1};

        // ---------------- reset values ----------------
        repeat (2) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_we", bwe, 0);
        chk("rst_addr", baddr, 0);
        chk("rst_wrdata", bwrdata, 0);
        chk("rst_count", cnt, 0);
        chk("rst_bram_rst", brst, 1);
        aresetn = 1'b1;
        chk("rel_awready_before_edge", awready, 0);
        tick();
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        exp_cnt = '0;

        // ---------------- table: simultaneous AW+W ----------------
        bready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            awaddr = vecs[i].addr; awvalid = 1'b1;
            wdata = vecs[i].data; wstrb = vecs[i].strb; wvalid = 1'b1;
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
            chk("tbl_held_awready", awready, 0);
            chk("tbl_held_wready", wready, 0);
            chk("tbl_held_we", bwe, 0);
            tick();
            if (vecs[i].exp_inc) exp_cnt++;
            chk("tbl_we", bwe, vecs[i].exp_we);
            chk("tbl_addr", baddr, vecs[i].exp_addr);
            chk("tbl_wrdata", bwrdata, vecs[i].data);
            chk("tbl_bvalid", bvalid, 1);
            chk("tbl_bresp", bresp, vecs[i].exp_resp);
            chk("tbl_count", cnt, exp_cnt);
            tick();
            chk("tbl_we_pulse_end", bwe, 0);
            chk("tbl_bvalid_clr", bvalid, 0);
            chk("tbl_awready_back", awready, 1);
        end

        // ---------------- W leads AW by 5 cycles ----------------
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wlead_wready", wready, 0);
        chk("wlead_awready", awready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wlead_we_idle", bwe, 0);
            chk("wlead_bvalid_idle", bvalid, 0);
            chk("wlead_wready_held", wready, 0);
        end
        awaddr = 32'h0000_0008; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wlead_we_pre", bwe, 0);
        tick();
        exp_cnt++;
        chk("wlead_addr", baddr, 2);
        chk("wlead_we", bwe, 4'hF);
        chk("wlead_wrdata", bwrdata, 32'hCAFE_F00D);
        chk("wlead_bvalid", bvalid, 1);
        chk("wlead_count", cnt, exp_cnt);
        tick();
        chk("wlead_we_end", bwe, 0);

        // ---------------- B backpressure ----------------
        bready = 1'b0;
        awaddr = 32'h0000_0100; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awaddr = 32'h0000_0104; wdata = 32'h5A5A_0002; wstrb = 4'h3;
        tick();
        exp_cnt++;
        chk("bp_first_we", bwe, 4'hF);
        chk("bp_first_addr", baddr, 64);
        chk("bp_first_bvalid", bvalid, 1);
        chk("bp_first_count", cnt, exp_cnt);
        chk("bp_awready_free", awready, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("bp_hold_awready", awready, 0);
            chk("bp_hold_wready", wready, 0);
            chk("bp_hold_we", bwe, 0);
            chk("bp_hold_bvalid", bvalid, 1);
            chk("bp_hold_bresp", bresp, 0);
            chk("bp_hold_count", cnt, exp_cnt);
            tick();
        end
        bready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_second_we", bwe, 4'h3);
        chk("bp_second_addr", baddr, 65);
        chk("bp_second_wrdata", bwrdata, 32'h5A5A_0002);
        chk("bp_second_bvalid", bvalid, 1);
        chk("bp_second_count", cnt, exp_cnt);
        tick();
        chk("bp_bvalid_clr", bvalid, 0);
        chk("bp_we_end", bwe, 0);

        // ---------------- randomized vs reference model ----------------
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        m_aw.delete(); m_wd.delete(); m_ws.delete();
        m_bv = 1'b0; m_resp = 2'b00; m_addr = '0; m_data = '0; m_we = '0; m_cnt = '0;
        for (int c = 0; c < 800; c++) begin
            if (!awvalid && ($urandom_range(0, 1) == 1)) begin
                awaddr  = $urandom & 32'h0000_1FFC;
                if ($urandom_range(0, 3) == 0) awaddr = awaddr | 32'hC000_0000;
                awvalid = 1'b1;
            end
            if (!wvalid && ($urandom_range(0, 1) == 1)) begin
                wdata  = $urandom;
                wstrb  = 4'($urandom_range(0, 15));
                wvalid = 1'b1;
            end
            bready = ($urandom_range(0, 3) != 0);

            chk("rnd_awready", awready, (m_aw.size() == 0));
            chk("rnd_wready", wready, (m_wd.size() == 0));
            chk("rnd_bvalid", bvalid, m_bv);
            if (m_bv) chk("rnd_bresp", bresp, m_resp);
            chk("rnd_we", bwe, m_we);
            chk("rnd_addr", baddr, m_addr);
            chk("rnd_wrdata", bwrdata, m_data);
            chk("rnd_count", cnt, m_cnt);

            aw_hs  = awvalid && (m_aw.size() == 0);
            w_hs   = wvalid && (m_wd.size() == 0);
            commit = (m_aw.size() > 0) && (m_wd.size() > 0) && (!m_bv || bready);
            if (commit) begin
                idx = m_aw.pop_front();
                d   = m_wd.pop_front();
                s   = m_ws.pop_front();
                ok  = in_rng(idx);
                m_addr = BAW'(idx);
                m_data = d;
                m_we   = ok ? s : '0;
                m_bv   = 1'b1;
                m_resp = ok ? 2'b00 : 2'b10;
                if (ok) m_cnt = m_cnt + 1'b1;
            end else begin
                m_we = '0;
                if (m_bv && bready) m_bv = 1'b0;
            end
            if (aw_hs) m_aw.push_back((awaddr / 4) % 1024);
            if (w_hs) begin
                m_wd.push_back(wdata);
                m_ws.push_back(wstrb);
            end
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;

        // ---------------- reset with AW held, then W only ----------------
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        bready = 1'b1;
        tick();
        awaddr = 32'h0000_0040; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("mid_aw_held", awready, 0);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_count", cnt, 0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("mid_rel_awready", awready, 1);
        wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_we", bwe, 0);
            chk("mid_no_bvalid", bvalid, 0);
            chk("mid_count", cnt, 0);
        end
        chk("mid_w_held", wready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
